// File: rtl/sym_frame_packer.sv
// Hunts for a 4-symbol sync word, then packs 2-bit symbols MSB-first into bytes
// handed out over valid/ready. Optional frame counter port under SYM_PACK_STATS_EN.
module sym_frame_packer #(
   parameter logic [7:0]  SYNC_WORD = 8'hB4,
   parameter int unsigned FRAME_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sym,
   input  logic       sym_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       in_frame,
   output logic       frame_done,
   output logic       ovf,
   input  logic       ovf_clr
`ifdef SYM_PACK_STATS_EN
   ,
   output logic [7:0] frame_cnt
`endif
);

   localparam logic [7:0] LastIdx = 8'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      StHunt = 2'b01,
      StPack = 2'b10
   } state_e;

   state_e     state_q;
   logic [7:0] sh_q;
   logic [1:0] sym_cnt_q;
   logic [7:0] byte_cnt_q;

   logic [7:0] sh_next;
   logic       byte_done;
   logic       last_byte;
   logic       load;

   // The sync register doubles as the payload accumulator: four shifts after sync
   // every bit of the byte is fresh payload.
   always_comb begin
      sh_next   = {sh_q[5:0], sym};
      byte_done = (state_q == StPack) && sym_valid && (sym_cnt_q == 2'd3);
      last_byte = byte_done && (byte_cnt_q == LastIdx);
      load      = byte_done && (!out_valid || out_ready);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StHunt;
         sh_q       <= '0;
         sym_cnt_q  <= '0;
         byte_cnt_q <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         in_frame   <= 1'b0;
         frame_done <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         if (out_valid && out_ready) out_valid <= 1'b0;
         if (load) begin
            out_data  <= sh_next;
            out_valid <= 1'b1;
         end

         // Overflow set is ordered after clear so it wins.
         if (ovf_clr) ovf <= 1'b0;
         if (byte_done && !load) ovf <= 1'b1;

         unique case (state_q)
            StHunt: begin
               if (sym_valid) begin
                  sh_q <= sh_next;
                  if (sh_next == SYNC_WORD) begin
                     state_q    <= StPack;
                     in_frame   <= 1'b1;
                     sym_cnt_q  <= '0;
                     byte_cnt_q <= '0;
                  end
               end
            end
            StPack: begin
               if (sym_valid) begin
                  sh_q      <= sh_next;
                  sym_cnt_q <= sym_cnt_q + 2'd1;
                  if (byte_done) begin
                     byte_cnt_q <= byte_cnt_q + 8'd1;
                     if (last_byte) begin
                        frame_done <= 1'b1;
                        state_q    <= StHunt;
                        in_frame   <= 1'b0;
                        sh_q       <= '0;
                     end
                  end
               end
            end
            default: begin
               state_q   <= StHunt;
               in_frame  <= 1'b0;
               sh_q      <= '0;
               sym_cnt_q <= '0;
            end
         endcase
      end
   end

`ifdef SYM_PACK_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= '0;
      end else if (last_byte) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sym_frame_packer.sv
// Directed bench for sym_frame_packer: two instances (FRAME_LEN 1 and 4) share stimulus.
module tb_sym_frame_packer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] sym = 2'd0;
   logic       sym_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic       ovf_clr = 1'b0;

   logic [7:0] d1_data, d4_data;
   logic       d1_valid, d4_valid, d1_frame, d4_frame, d1_done, d4_done, d1_ovf, d4_ovf;
`ifdef SYM_PACK_STATS_EN
   logic [7:0] d1_fcnt, d4_fcnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sym_frame_packer #(.SYNC_WORD(8'hB4), .FRAME_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .sym(sym), .sym_valid(sym_valid),
      .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
      .in_frame(d1_frame), .frame_done(d1_done), .ovf(d1_ovf), .ovf_clr(ovf_clr)
`ifdef SYM_PACK_STATS_EN
      , .frame_cnt(d1_fcnt)
`endif
   );

   sym_frame_packer #(.SYNC_WORD(8'hB4), .FRAME_LEN(4)) dut4 (
      .clk(clk), .rst(rst), .sym(sym), .sym_valid(sym_valid),
      .out_data(d4_data), .out_valid(d4_valid), .out_ready(out_ready),
      .in_frame(d4_frame), .frame_done(d4_done), .ovf(d4_ovf), .ovf_clr(ovf_clr)
`ifdef SYM_PACK_STATS_EN
      , .frame_cnt(d4_fcnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] s);
      sym       = s;
      sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      for (int i = 3; i >= 0; i--) begin
         send(b[2*i+1 -: 2]);
         if (gaps && i != 0) begin
            tick();
            tick();
         end
      end
   endtask

   task automatic do_reset();
      sym_valid = 1'b0;
      ovf_clr   = 1'b0;
      rst       = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      // 1: reset values, FRAME_LEN=1 frame
      out_ready = 1'b1;
      do_reset();
      check("rst_data", d1_data, 0);
      check("rst_valid", d1_valid, 0);
      check("rst_in_frame", d1_frame, 0);
      check("rst_done", d1_done, 0);
      check("rst_ovf", d1_ovf, 0);
`ifdef SYM_PACK_STATS_EN
      check("rst_fcnt", d1_fcnt, 0);
`endif
      send_byte(8'hB4, 1'b0);
      check("t1_in_frame", d1_frame, 1);
      send(2'b11); send(2'b00); send(2'b01);
      check("t1_valid_early", d1_valid, 0);
      send(2'b10);
      check("t1_data", d1_data, 8'hC6);
      check("t1_valid", d1_valid, 1);
      check("t1_done", d1_done, 1);
      check("t1_hunt", d1_frame, 0);
      tick();
      check("t1_done_pulse", d1_done, 0);
      check("t1_consumed", d1_valid, 0);

      // 2: sync preceded by junk
      do_reset();
      send(2'b10); send(2'b10); send(2'b11); send(2'b01);
      check("t2_no_sync_yet", d1_frame, 0);
      send(2'b00);
      check("t2_sync", d1_frame, 1);

      // 3: back-pressure overflow on FRAME_LEN=4
      out_ready = 1'b0;
      do_reset();
      send_byte(8'hB4, 1'b0);
      send_byte(8'h12, 1'b0);
      check("t3_b1_valid", d4_valid, 1);
      check("t3_b1_data", d4_data, 8'h12);
      check("t3_b1_ovf", d4_ovf, 0);
      send_byte(8'h34, 1'b0);
      check("t3_b2_held", d4_data, 8'h12);
      check("t3_b2_ovf", d4_ovf, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("t3_clr", d4_ovf, 0);
      send(2'b01); send(2'b01); send(2'b01);
      ovf_clr = 1'b1;
      send(2'b10);
      ovf_clr = 1'b0;
      check("t3_set_wins", d4_ovf, 1);
      check("t3_b3_held", d4_data, 8'h12);
      check("t3_b3_in_frame", d4_frame, 1);
      send_byte(8'h78, 1'b0);
      check("t3_b4_done", d4_done, 1);
      check("t3_b4_hunt", d4_frame, 0);
      check("t3_b4_held", d4_data, 8'h12);
      out_ready = 1'b1;
      tick();
      check("t3_drain", d4_valid, 0);

      // 4: accept and complete on the same edge
      out_ready = 1'b0;
      do_reset();
      send_byte(8'hB4, 1'b0);
      send_byte(8'h9A, 1'b0);
      tick();
      check("t4_hold_valid", d4_valid, 1);
      check("t4_hold_data", d4_data, 8'h9A);
      send(2'b10); send(2'b11); send(2'b11);
      out_ready = 1'b1;
      send(2'b00);
      out_ready = 1'b0;
      check("t4_new_data", d4_data, 8'hBC);
      check("t4_valid", d4_valid, 1);
      check("t4_ovf", d4_ovf, 0);

      // 5: async reset mid-byte with a pending output
      do_reset();
      send_byte(8'hB4, 1'b0);
      send_byte(8'h5A, 1'b0);
      send(2'b11); send(2'b11);
      #2 rst = 1'b0;
      #1;
      check("t5_valid", d4_valid, 0);
      check("t5_data", d4_data, 0);
      check("t5_in_frame", d4_frame, 0);
      tick();
      rst = 1'b1;
      out_ready = 1'b1;
      send_byte(8'hB4, 1'b0);
      check("t5_resync", d4_frame, 1);
      send_byte(8'hE1, 1'b0);
      check("t5_data_ok", d4_data, 8'hE1);

      // 6: three FRAME_LEN=1 frames with gaps
      do_reset();
      send_byte(8'hB4, 1'b1);
      tick();
      send_byte(8'h5A, 1'b1);
      check("t6_f1", d1_data, 8'h5A);
      tick();
      send_byte(8'hB4, 1'b1);
      send_byte(8'hA5, 1'b1);
      check("t6_f2", d1_data, 8'hA5);
      tick();
      tick();
      send_byte(8'hB4, 1'b1);
      send_byte(8'h3C, 1'b1);
      check("t6_f3", d1_data, 8'h3C);
      check("t6_done", d1_done, 1);
`ifdef SYM_PACK_STATS_EN
      tick();
      check("t6_fcnt", d1_fcnt, 3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
